// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/mult_div_unit_adder.sv
// 32-bit adder shared by every multiply/divide step; carry-out drives the divide decision.
module ThirtyTwoBitAdder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cin,
  output logic [31:0] S,
  output logic        cout,
  output logic        overFlow
);

  always_comb begin
    {cout, S} = {1'b0, A} + {1'b0, B} + {32'd0, cin};
    overFlow  = (A[31] == B[31]) && (S[31] != A[31]);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed 34-cycle latency per operation.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned ITER = mdu_pkg::ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           state, state_nxt;
  op_e              opr;
  logic [31:0]      p, q, m;
  logic [CNT_W-1:0] cnt;
  logic             neg_res, neg_rem, dbz;

  logic             is_div;
  logic             sgn_a, sgn_b;
  logic [31:0]      abs_a, abs_b;
  logic [63:0]      prod_neg;
  logic [31:0]      add_a, add_b, add_s;
  logic             add_cin, add_co, add_unused_ovf;
  logic             div_ok;

  assign is_div = opr[1];

  // Raw operands sit in m (a) and q (b) between acceptance and PREP.
  assign sgn_a    = opr[0] & m[31];
  assign sgn_b    = opr[0] & q[31];
  assign abs_a    = sgn_a ? neg32(m) : m;
  assign abs_b    = sgn_b ? neg32(q) : q;
  assign prod_neg = ~{p, q} + 64'd1;

  always_comb begin
    add_a   = p;
    add_b   = m;
    add_cin = 1'b0;
    if (is_div) begin
      add_a   = {p[30:0], q[31]};
      add_b   = ~m;
      add_cin = 1'b1;
    end
  end

  ThirtyTwoBitAdder u_add (
    .A        (add_a),
    .B        (add_b),
    .cin      (add_cin),
    .S        (add_s),
    .cout     (add_co),
    .overFlow (add_unused_ovf)
  );

  // The bit shifted out of R is the 33rd remainder bit; when set, the subtract cannot borrow.
  assign div_ok = add_co | p[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr         <= OP_MULTU;
      p           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            opr <= op_e'(op);
            m   <= a;
            q   <= b;
          end
        end
        PREP: begin
          p       <= '0;
          cnt     <= '0;
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= sgn_a;
          dbz     <= is_div & (q == 32'd0);
          if (is_div) begin
            q <= abs_a;
            m <= abs_b;
          end else begin
            q <= abs_b;
            m <= abs_a;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            p <= div_ok ? add_s : add_a;
            q <= {q[30:0], div_ok};
          end else if (q[0]) begin
            p <= {add_co, add_s[31:1]};
            q <= {add_s[0], q[31:1]};
          end else begin
            p <= {1'b0, p[31:1]};
            q <= {p[0], q[31:1]};
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz;
          if (is_div) begin
            lo <= neg_res ? neg32(q) : q;
            hi <= neg_rem ? neg32(p) : p;
          end else begin
            {hi, lo} <= neg_res ? prod_neg : {p, q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.ITER(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx, sy, qt, rm;
    logic [63:0] r;
    logic        z;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    z  = 1'b0;
    r  = '0;
    case (o)
      2'b00: r = {32'd0, x} * {32'd0, y};
      2'b01: r = 64'(sx * sy);
      2'b10: begin
        if (y == 32'd0) begin
          r = {x, 32'hFFFFFFFF};
          z = 1'b1;
        end else begin
          r = {x % y, x / y};
        end
      end
      default: begin
        if (y == 32'd0) begin
          z = 1'b1;
          r = {x, (x[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        end else begin
          qt = sx / sy;
          rm = sx % sy;
          r  = {rm[31:0], qt[31:0]};
        end
      end
    endcase
    return {z, r};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int mode);
    logic [64:0] e;
    int          lat;
    e = ref_model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    check("busy_after_start", busy, 1);
    check("done_low_after_start", done, 0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mode == 1 && i == 9) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("latency", lat, 34);
    check("busy_at_done", busy, 0);
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
    check("div_by_zero", div_by_zero, e[64]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #22;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'b01, 32'hFFFFFFF9, 32'd3, 0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0);
    run_op(2'b10, 32'd100, 32'd7, 0);
    run_op(2'b10, 32'h12345678, 32'd0, 0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'b01, 32'h80000000, 32'h80000000, 0);
    run_op(2'b11, 32'hFFFFFFFB, 32'd0, 0);
    run_op(2'b10, 32'hFFFFFFFF, 32'h80000001, 0);
    run_op(2'b01, 32'd12345, 32'hFFFFFC19, 1);

    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", lo, 32'hA5A5A5A5);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h5A5A0F0F;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi", hi, 32'h5A5A0F0F);

    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hDEADBEEF; b = 32'h01234567;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b10, 32'd9, 32'd3, 0);

    for (int n = 0; n < 30; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = $urandom_range(1, 20);
        default: ;
      endcase
      run_op(ro, ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. Each step of the computation goes through a ThirtyTwoBitAdder instance. The unit sits beside the ALU and is read by MFHI/MFLO through the `hi`/`lo` outputs. The pipeline stalls on `busy`.

## Interface
- `ITER`, default 32: iterations per operation. Fixed to the operand width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: launches an operation. Sampled only while idle.
- `op` in 2: operation select. 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32: rs operand (multiplicand or dividend). Sampled with `start`.
- `b` in 32: rt operand (multiplier or divisor). Sampled with `start`.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse. HI/LO are updated in this cycle.
- `div_by_zero` out 1: pulses with `done` when a DIV or DIVU had `b == 0`.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States:
  - IDLE: accept work.
  - PREP: take operand magnitudes; record result signs.
  - CALC: `ITER` shift/add or shift/subtract steps.
  - FIX: apply signs; write HI/LO.
- Transitions:
  - IDLE to PREP on `start`.
  - PREP to CALC unconditionally.
  - CALC to FIX when the 5-bit step counter reaches 31.
  - FIX to IDLE.
- Multiply uses radix-2 shift-add.
  - 64-bit product register {P, Q}. Q is loaded with |b|; P starts at 0.
  - Each step: if Q[0], add |a| to P via the adder, keeping the carry-out. Then shift {cout, P, Q} right by one.
  - Result: HI = product[63:32], LO = product[31:0].
- Divide uses restoring division.
  - Remainder R starts at 0. Q is loaded with |a|.
  - Each step: shift {R, Q} left by one. Compute R - |b| via the adder with `cin` = 1 and B = ~|b|.
  - If the carry-out is 1 (no borrow), write the difference back to R and set Q[0] = 1. Otherwise keep R and set Q[0] = 0.
  - Result: LO = quotient, HI = remainder.
- Signed operations (MULT, DIV):
  - Negative operands are two's-complement negated in PREP.
  - MULT: the 64-bit product is negated in FIX if the operand signs differ.
  - DIV: the quotient is negated if the signs differ. The remainder takes the sign of the dividend.
- Boundary results:
  - Divide by zero: the datapath runs unmodified. DIVU gives LO = 32'hFFFFFFFF, HI = `a`. DIV gives the same values after sign fixup applied to the raw result. `div_by_zero` pulses.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No flag.
  - MULT 32'h80000000 × 32'h80000000: HI = 32'h40000000, LO = 0.
- Start handling:
  - `start` while busy is ignored.
  - `op`, `a` and `b` are not required to stay stable after acceptance.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write `wdata` at the next edge, and only while in IDLE. They are ignored while busy.
  - If `hi_we` coincides with an accepted `start`, the write lands first. The operation result overwrites it at `done`.
- Reset (asserted at any time, including mid-operation):
  - Aborts the operation and returns to IDLE.
  - `hi` = `lo` = 0; `busy` = `done` = `div_by_zero` = 0; step counter = 0.

## Timing
- Edge 0 samples `start`. `busy` rises after edge 0.
- Edge 1 enters CALC.
- Edges 2 through 33 perform the 32 steps.
- Edge 34 registers HI/LO. `done` is high for the single cycle following edge 34, with new `hi`/`lo` visible in that same cycle, and `busy` falls in that cycle.
- Latency is 34 cycles from `start` to `done` for every op and operand value. There is no early termination.
- A new `start` is accepted in the cycle `done` is high, giving back-to-back operations.
- `hi`/`lo` are registered outputs and hold their value between writes.
- The adder is combinational inside one CALC cycle. Register-to-register timing is a single 32-bit CLA plus a mux.

## Structure
- Package `mdu_pkg` holds:
  - the op encodings MULTU/MULT/DIVU/DIV;
  - the state enum IDLE/PREP/CALC/FIX;
  - `ITER` = 32 and a 5-bit counter width constant.
- Exactly one ThirtyTwoBitAdder instance serves the step add/subtract, with its `overFlow` output unused.
- PREP/FIX negation uses local ~x + 1 logic. No second sub-module.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → after 34 cycles HI = 32'hFFFFFFFE, LO = 32'h00000001, `done` pulses once.
- MULT -7 × 3 → HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB.
- DIV -7 / 2 → LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIVU 32'h12345678 / 0 → LO = 32'hFFFFFFFF, HI = 32'h12345678, `div_by_zero` = 1 with `done`.
- `start` pulsed at cycle 10 of a running op, and `hi_we` during busy → both ignored. MTLO 32'hA5A5A5A5 while idle → `lo` updates next cycle.
- `rst_n` dropped at step 15 of a MULT → `busy` = 0 and `hi` = `lo` = 0 immediately. A subsequent DIVU 9 / 3 gives LO = 3, HI = 0 in 34 cycles.
